// File: rtl/pifo_calendar_v0_2_if.sv
`default_nettype none
// ============================================================================
//  Module      : pifo_calendar_v0_2_if
//  Description : Insert/pop handshake and status bundle for the PIFO calendar.
//                The slave modport is the calendar itself; the master modport
//                is the producer/consumer side that talks to it.
//  Revision    : 0.2 - initial interface for the parametrised calendar
// ============================================================================
interface pifo_calendar_v0_2_if #(
    parameter int ELEM_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 5
);
    logic                  s_ins_valid;
    logic                  s_ins_ready;
    logic [ELEM_WIDTH-1:0] s_ins_data;
    logic                  m_pop_valid;
    logic                  m_pop_ready;
    logic [ELEM_WIDTH-1:0] m_pop_data;
    logic [ADDR_WIDTH-1:0] m_pop_addr;
    logic [CNT_WIDTH-1:0]  m_count;
    logic                  m_almost_full;
    logic                  m_drop_pulse;
    logic [15:0]           m_drop_count;

    modport slave (
        input  s_ins_valid, s_ins_data, m_pop_ready,
        output s_ins_ready, m_pop_valid, m_pop_data, m_pop_addr,
               m_count, m_almost_full, m_drop_pulse, m_drop_count
    );

    modport master (
        output s_ins_valid, s_ins_data, m_pop_ready,
        input  s_ins_ready, m_pop_valid, m_pop_data, m_pop_addr,
               m_count, m_almost_full, m_drop_pulse, m_drop_count
    );
endinterface
`default_nettype wire

// File: rtl/pifo_calendar_v0_2.sv
`default_nettype none
// ============================================================================
//  Module      : pifo_calendar_v0_2
//  Description : Sorted-array PIFO calendar. Entries are kept contiguous from
//                e[0] in ascending rank order, FIFO among equal ranks. One
//                insert and one pop may complete per cycle. Optional
//                evict-tail drop mode with a saturating drop counter, and a
//                hysteresis almost-full flag.
//  Revision    : 0.2 - parametrised successor of the root-only calendar
// ============================================================================
module pifo_calendar_v0_2 #(
    parameter int DEPTH          = 16,
    parameter int ELEM_WIDTH     = 32,
    parameter int RANK_LSB       = 12,
    parameter int RANK_WIDTH     = 18,
    parameter int ADDR_WIDTH     = 12,
    parameter int CNT_WIDTH      = 5,
    parameter int FULL_ON        = DEPTH - 2,
    parameter int FULL_OFF       = DEPTH / 2,
    parameter int DROP_WHEN_FULL = 0
) (
    input  wire logic               clk,
    input  wire logic               rstn,
    pifo_calendar_v0_2_if.slave     pifo_bus
);

    localparam logic [0:0]           c_st_normal = 1'b0;
    localparam logic [0:0]           c_st_full   = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_depth     = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_full_on   = CNT_WIDTH'(FULL_ON);
    localparam logic [CNT_WIDTH-1:0] c_full_off  = CNT_WIDTH'(FULL_OFF);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ELEM_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [0:0]            r_state;
    logic                  r_drop_pulse;
    logic [15:0]           r_drop_count;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [RANK_WIDTH-1:0] w_rank_in;
    logic                  w_full;
    logic                  w_ins_ready;
    logic                  w_ins;
    logic                  w_pop;
    logic                  w_drop;
    logic [DEPTH-1:0]      w_le;
    logic [CNT_WIDTH-1:0]  w_p;
    logic [CNT_WIDTH-1:0]  w_q;
    logic [ELEM_WIDTH-1:0] w_up_data [DEPTH];
    logic [DEPTH-1:0]      w_up_valid;
    logic [ELEM_WIDTH-1:0] w_dn_data [DEPTH];
    logic [DEPTH-1:0]      w_dn_valid;
    logic [ELEM_WIDTH-1:0] w_data_nxt [DEPTH];
    logic [DEPTH-1:0]      w_valid_nxt;
    logic [0:0]            w_state_nxt;
    logic                  w_almost_full;

    assign w_rank_in = pifo_bus.s_ins_data[RANK_LSB +: RANK_WIDTH];
    assign w_full    = (r_count == c_depth);

    // Ready depends only on the registered count, never on s_ins_valid.
    if (DROP_WHEN_FULL != 0) begin : g_ready_drop
        assign w_ins_ready = 1'b1;
    end else begin : g_ready_bp
        assign w_ins_ready = !w_full;
    end

    assign w_ins  = pifo_bus.s_ins_valid & w_ins_ready;
    assign w_pop  = r_valid[0] & pifo_bus.m_pop_ready;
    // Only reachable in drop mode: a full array with no pop to make room.
    assign w_drop = w_ins & ~w_pop & w_full;

    // Per-entry "rank <= incoming rank" flags and neighbour views used by
    // the shift-up (toward head) and shift-down (toward tail) moves.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign w_le[gi] = r_valid[gi] &&
                          (r_data[gi][RANK_LSB +: RANK_WIDTH] <= w_rank_in);

        if (gi == DEPTH - 1) begin : g_up_tail
            assign w_up_data[gi]  = '0;
            assign w_up_valid[gi] = 1'b0;
        end else begin : g_up_body
            assign w_up_data[gi]  = r_data[gi+1];
            assign w_up_valid[gi] = r_valid[gi+1];
        end

        if (gi == 0) begin : g_dn_head
            assign w_dn_data[gi]  = '0;
            assign w_dn_valid[gi] = 1'b0;
        end else begin : g_dn_body
            assign w_dn_data[gi]  = r_data[gi-1];
            assign w_dn_valid[gi] = r_valid[gi-1];
        end
    end

    // Insert position: entries are sorted and contiguous, so the number of
    // valid entries with rank <= new rank is exactly the slot after the ties.
    always_comb begin
        w_p = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_p = w_p + CNT_WIDTH'(w_le[i]);
        end
    end

    // Slot for a simultaneous insert+pop: the head leaves, so everything in
    // front of the insert point moves up one place.
    assign w_q = (w_p == '0) ? '0 : (w_p - 1'b1);

    // Next array contents for insert-only, pop-only and insert+pop.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_data_nxt[i]  = r_data[i];
            w_valid_nxt[i] = r_valid[i];
            if (w_ins && w_pop) begin
                if (CNT_WIDTH'(i) < w_q) begin
                    w_data_nxt[i]  = w_up_data[i];
                    w_valid_nxt[i] = w_up_valid[i];
                end else if (CNT_WIDTH'(i) == w_q) begin
                    w_data_nxt[i]  = pifo_bus.s_ins_data;
                    w_valid_nxt[i] = 1'b1;
                end
            end else if (w_ins) begin
                // When full in drop mode this naturally discards the old tail,
                // or leaves the array untouched if the new rank goes past it.
                if (CNT_WIDTH'(i) == w_p) begin
                    w_data_nxt[i]  = pifo_bus.s_ins_data;
                    w_valid_nxt[i] = 1'b1;
                end else if (CNT_WIDTH'(i) > w_p) begin
                    w_data_nxt[i]  = w_dn_data[i];
                    w_valid_nxt[i] = w_dn_valid[i];
                end
            end else if (w_pop) begin
                w_data_nxt[i]  = w_up_data[i];
                w_valid_nxt[i] = w_up_valid[i];
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= w_data_nxt[i];
            end
            r_valid <= w_valid_nxt;
        end
    end

    // Occupancy counter; a drop keeps the count at DEPTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (w_ins && !w_pop && !w_full) begin
            r_count <= r_count + 1'b1;
        end else if (w_pop && !w_ins) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_drop_pulse <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    // Almost-full FSM: state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_st_normal;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Almost-full FSM: next state from the registered count with hysteresis.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_normal: if (r_count > c_full_on)  w_state_nxt = c_st_full;
            c_st_full:   if (r_count < c_full_off) w_state_nxt = c_st_normal;
            default:     w_state_nxt = c_st_normal;
        endcase
    end

    // Almost-full FSM: output decode.
    always_comb begin
        w_almost_full = 1'b0;
        if (r_state == c_st_full) begin
            w_almost_full = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pifo_bus.s_ins_ready   = w_ins_ready;
    assign pifo_bus.m_pop_valid   = r_valid[0];
    assign pifo_bus.m_pop_data    = r_data[0];
    assign pifo_bus.m_pop_addr    = r_data[0][ADDR_WIDTH-1:0];
    assign pifo_bus.m_count       = r_count;
    assign pifo_bus.m_almost_full = w_almost_full;
    assign pifo_bus.m_drop_pulse  = r_drop_pulse;
    assign pifo_bus.m_drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_pifo_calendar_v0_2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pifo_calendar_v0_2
//  Description : Directed self-checking bench for the PIFO calendar. Three
//                instances: DEPTH=4 backpressure, DEPTH=4 drop mode, and
//                DEPTH=16 for the almost-full hysteresis.
//  Revision    : 0.2 - initial bench
// ============================================================================
module tb_pifo_calendar_v0_2;

    logic clk;
    logic rstn;
    int   tests;
    int   failed;

    pifo_calendar_v0_2_if #(.ELEM_WIDTH(32), .ADDR_WIDTH(12), .CNT_WIDTH(5)) if_a ();
    pifo_calendar_v0_2_if #(.ELEM_WIDTH(32), .ADDR_WIDTH(12), .CNT_WIDTH(5)) if_d ();
    pifo_calendar_v0_2_if #(.ELEM_WIDTH(32), .ADDR_WIDTH(12), .CNT_WIDTH(5)) if_h ();

    pifo_calendar_v0_2 #(.DEPTH(4), .DROP_WHEN_FULL(0)) u_bp (
        .clk(clk), .rstn(rstn), .pifo_bus(if_a));
    pifo_calendar_v0_2 #(.DEPTH(4), .DROP_WHEN_FULL(1)) u_drop (
        .clk(clk), .rstn(rstn), .pifo_bus(if_d));
    pifo_calendar_v0_2 #(.DEPTH(16), .DROP_WHEN_FULL(0)) u_hyst (
        .clk(clk), .rstn(rstn), .pifo_bus(if_h));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int rank, input int tag);
        logic [31:0] e;
        e = (32'(rank) << 12) | (32'(tag) & 32'h0000_0FFF);
        return e;
    endfunction

    // Drive one cycle on the selected instance (0=bp, 1=drop, 2=hyst);
    // returns #1 after the clock edge with all requests deasserted.
    task automatic step(input int sel, input logic v, input logic [31:0] d, input logic p);
        case (sel)
            0:       begin if_a.s_ins_valid = v; if_a.s_ins_data = d; if_a.m_pop_ready = p; end
            1:       begin if_d.s_ins_valid = v; if_d.s_ins_data = d; if_d.m_pop_ready = p; end
            default: begin if_h.s_ins_valid = v; if_h.s_ins_data = d; if_h.m_pop_ready = p; end
        endcase
        @(posedge clk);
        #1;
        if_a.s_ins_valid = 1'b0; if_a.m_pop_ready = 1'b0;
        if_d.s_ins_valid = 1'b0; if_d.m_pop_ready = 1'b0;
        if_h.s_ins_valid = 1'b0; if_h.m_pop_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (if_a.m_pop_valid !== 1'b0) begin failed++; $display("FAIL rst_pop_valid got %0b exp 0", if_a.m_pop_valid); end
        tests++; if (if_a.m_pop_data !== 32'd0) begin failed++; $display("FAIL rst_pop_data got %h exp 0", if_a.m_pop_data); end
        tests++; if (if_a.m_pop_addr !== 12'd0) begin failed++; $display("FAIL rst_pop_addr got %h exp 0", if_a.m_pop_addr); end
        tests++; if (if_a.m_count !== 5'd0) begin failed++; $display("FAIL rst_count got %0d exp 0", if_a.m_count); end
        tests++; if (if_a.m_almost_full !== 1'b0) begin failed++; $display("FAIL rst_almost_full got %0b exp 0", if_a.m_almost_full); end
        tests++; if (if_a.s_ins_ready !== 1'b1) begin failed++; $display("FAIL rst_ins_ready got %0b exp 1", if_a.s_ins_ready); end
        tests++; if (if_d.m_drop_pulse !== 1'b0) begin failed++; $display("FAIL rst_drop_pulse got %0b exp 0", if_d.m_drop_pulse); end
        tests++; if (if_d.m_drop_count !== 16'd0) begin failed++; $display("FAIL rst_drop_count got %0d exp 0", if_d.m_drop_count); end
    endtask

    task automatic test_sorted_insert();
        int          ranks [4] = '{5, 2, 9, 2};
        int          tags  [4] = '{1, 'hA, 2, 'hB};
        logic [31:0] heads [4];
        logic [31:0] order [4];
        heads[0] = mk(5, 1);   heads[1] = mk(2, 'hA); heads[2] = mk(2, 'hA); heads[3] = mk(2, 'hA);
        order[0] = mk(2, 'hA); order[1] = mk(2, 'hB); order[2] = mk(5, 1);   order[3] = mk(9, 2);
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, mk(ranks[i], tags[i]), 1'b0);
            tests++; if (if_a.m_count !== 5'(i + 1)) begin failed++; $display("FAIL sort_ins_count[%0d] got %0d exp %0d", i, if_a.m_count, i + 1); end
            tests++; if (if_a.m_pop_data !== heads[i]) begin failed++; $display("FAIL sort_ins_head[%0d] got %h exp %h", i, if_a.m_pop_data, heads[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            tests++; if (if_a.m_pop_data !== order[i]) begin failed++; $display("FAIL sort_pop_data[%0d] got %h exp %h", i, if_a.m_pop_data, order[i]); end
            tests++; if (if_a.m_pop_addr !== order[i][11:0]) begin failed++; $display("FAIL sort_pop_addr[%0d] got %h exp %h", i, if_a.m_pop_addr, order[i][11:0]); end
            step(0, 1'b0, 32'd0, 1'b1);
            tests++; if (if_a.m_count !== 5'(3 - i)) begin failed++; $display("FAIL sort_pop_count[%0d] got %0d exp %0d", i, if_a.m_count, 3 - i); end
        end
        tests++; if (if_a.m_pop_valid !== 1'b0) begin failed++; $display("FAIL sort_empty_valid got %0b exp 0", if_a.m_pop_valid); end
    endtask

    task automatic test_simultaneous();
        int exp_drain [3] = '{7, 8, 10};
        step(0, 1'b1, mk(3, 3), 1'b0);
        step(0, 1'b1, mk(7, 7), 1'b0);
        step(0, 1'b1, mk(8, 8), 1'b0);
        step(0, 1'b1, mk(1, 1), 1'b1);
        tests++; if (if_a.m_pop_data !== mk(1, 1)) begin failed++; $display("FAIL sim1_head got %h exp %h", if_a.m_pop_data, mk(1, 1)); end
        tests++; if (if_a.m_count !== 5'd3) begin failed++; $display("FAIL sim1_count got %0d exp 3", if_a.m_count); end
        step(0, 1'b1, mk(10, 10), 1'b1);
        tests++; if (if_a.m_count !== 5'd3) begin failed++; $display("FAIL sim2_count got %0d exp 3", if_a.m_count); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (if_a.m_pop_data !== mk(exp_drain[i], exp_drain[i])) begin failed++; $display("FAIL sim2_drain[%0d] got %h exp %h", i, if_a.m_pop_data, mk(exp_drain[i], exp_drain[i])); end
            step(0, 1'b0, 32'd0, 1'b1);
        end
        tests++; if (if_a.m_count !== 5'd0) begin failed++; $display("FAIL sim_final_count got %0d exp 0", if_a.m_count); end
    endtask

    task automatic test_backpressure();
        for (int i = 4; i >= 1; i--) step(0, 1'b1, mk(i, i), 1'b0);
        tests++; if (if_a.m_count !== 5'd4) begin failed++; $display("FAIL bp_full_count got %0d exp 4", if_a.m_count); end
        tests++; if (if_a.s_ins_ready !== 1'b0) begin failed++; $display("FAIL bp_ready_full got %0b exp 0", if_a.s_ins_ready); end
        step(0, 1'b1, mk(0, 'hF), 1'b1);
        tests++; if (if_a.m_count !== 5'd3) begin failed++; $display("FAIL bp_count_after got %0d exp 3", if_a.m_count); end
        tests++; if (if_a.m_pop_data !== mk(2, 2)) begin failed++; $display("FAIL bp_head_after got %h exp %h", if_a.m_pop_data, mk(2, 2)); end
        tests++; if (if_a.s_ins_ready !== 1'b1) begin failed++; $display("FAIL bp_ready_after got %0b exp 1", if_a.s_ins_ready); end
        for (int i = 0; i < 3; i++) step(0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_drop();
        int init [4] = '{1, 4, 6, 8};
        int fin  [4] = '{1, 4, 5, 6};
        for (int i = 0; i < 4; i++) step(1, 1'b1, mk(init[i], init[i]), 1'b0);
        tests++; if (if_d.s_ins_ready !== 1'b1) begin failed++; $display("FAIL drop_ready_full got %0b exp 1", if_d.s_ins_ready); end
        step(1, 1'b1, mk(5, 5), 1'b0);
        tests++; if (if_d.m_drop_pulse !== 1'b1) begin failed++; $display("FAIL drop_pulse1 got %0b exp 1", if_d.m_drop_pulse); end
        tests++; if (if_d.m_drop_count !== 16'd1) begin failed++; $display("FAIL drop_count1 got %0d exp 1", if_d.m_drop_count); end
        tests++; if (if_d.m_count !== 5'd4) begin failed++; $display("FAIL drop_occ1 got %0d exp 4", if_d.m_count); end
        step(1, 1'b0, 32'd0, 1'b0);
        tests++; if (if_d.m_drop_pulse !== 1'b0) begin failed++; $display("FAIL drop_pulse_idle got %0b exp 0", if_d.m_drop_pulse); end
        step(1, 1'b1, mk(9, 9), 1'b0);
        tests++; if (if_d.m_drop_pulse !== 1'b1) begin failed++; $display("FAIL drop_pulse2 got %0b exp 1", if_d.m_drop_pulse); end
        tests++; if (if_d.m_drop_count !== 16'd2) begin failed++; $display("FAIL drop_count2 got %0d exp 2", if_d.m_drop_count); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (if_d.m_pop_data !== mk(fin[i], fin[i])) begin failed++; $display("FAIL drop_drain[%0d] got %h exp %h", i, if_d.m_pop_data, mk(fin[i], fin[i])); end
            step(1, 1'b0, 32'd0, 1'b1);
        end
        tests++; if (if_d.m_pop_valid !== 1'b0) begin failed++; $display("FAIL drop_empty got %0b exp 0", if_d.m_pop_valid); end
    endtask

    task automatic test_hysteresis();
        logic exp_af;
        for (int k = 1; k <= 15; k++) begin
            step(2, 1'b1, mk(k, k), 1'b0);
            tests++; if (if_h.m_almost_full !== 1'b0) begin failed++; $display("FAIL hyst_fill_af[%0d] got %0b exp 0", k, if_h.m_almost_full); end
        end
        step(2, 1'b0, 32'd0, 1'b0);
        tests++; if (if_h.m_almost_full !== 1'b1) begin failed++; $display("FAIL hyst_rise got %0b exp 1", if_h.m_almost_full); end
        // After each pop the flag reflects the count before that pop:
        // still high while that previous count was >= 8.
        for (int c = 14; c >= 0; c--) begin
            step(2, 1'b0, 32'd0, 1'b1);
            exp_af = (c >= 7);
            tests++; if (if_h.m_almost_full !== exp_af) begin failed++; $display("FAIL hyst_drain_af[count=%0d] got %0b exp %0b", c, if_h.m_almost_full, exp_af); end
        end
        tests++; if (if_h.m_count !== 5'd0) begin failed++; $display("FAIL hyst_final_count got %0d exp 0", if_h.m_count); end
    endtask

    task automatic test_async_reset();
        step(0, 1'b1, mk(6, 6), 1'b0);
        step(0, 1'b1, mk(3, 3), 1'b0);
        step(0, 1'b1, mk(4, 4), 1'b0);
        tests++; if (if_a.m_count !== 5'd3) begin failed++; $display("FAIL arst_pre_count got %0d exp 3", if_a.m_count); end
        #2;
        rstn = 1'b0;
        #1;
        tests++; if (if_a.m_pop_valid !== 1'b0) begin failed++; $display("FAIL arst_pop_valid got %0b exp 0", if_a.m_pop_valid); end
        tests++; if (if_a.m_pop_data !== 32'd0) begin failed++; $display("FAIL arst_pop_data got %h exp 0", if_a.m_pop_data); end
        tests++; if (if_a.m_count !== 5'd0) begin failed++; $display("FAIL arst_count got %0d exp 0", if_a.m_count); end
        tests++; if (if_a.s_ins_ready !== 1'b1) begin failed++; $display("FAIL arst_ready got %0b exp 1", if_a.s_ins_ready); end
        tests++; if (if_d.m_drop_count !== 16'd0) begin failed++; $display("FAIL arst_drop_count got %0d exp 0", if_d.m_drop_count); end
        @(negedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        step(0, 1'b1, mk(9, 5), 1'b0);
        tests++; if (if_a.m_pop_data !== mk(9, 5)) begin failed++; $display("FAIL arst_first_head got %h exp %h", if_a.m_pop_data, mk(9, 5)); end
        tests++; if (if_a.m_count !== 5'd1) begin failed++; $display("FAIL arst_first_count got %0d exp 1", if_a.m_count); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rstn   = 1'b0;
        if_a.s_ins_valid = 1'b0; if_a.s_ins_data = '0; if_a.m_pop_ready = 1'b0;
        if_d.s_ins_valid = 1'b0; if_d.s_ins_data = '0; if_d.m_pop_ready = 1'b0;
        if_h.s_ins_valid = 1'b0; if_h.s_ins_data = '0; if_h.m_pop_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        test_reset();
        test_sorted_insert();
        test_simultaneous();
        test_backpressure();
        test_drop();
        test_hysteresis();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
